elastic_fifo: RTL
=================

// Module: elastic_fifo
// PURPOSE
//   Parametrised synchronous FIFO used on CGRA PE/interconnect data channels.
//   Adds to the basic data FIFO: arbitrary depth (including non-power-of-two),
//   a selectable output mode, an occupancy count, almost-full/almost-empty flags,
//   a synchronous flush and a sticky overflow flag.
//   Sits between a producer and consumer using valid/ready handshakes on both sides.
// PARAMETERS
//   DATA_WIDTH  32  payload width in bits (>=1)
//   FIFO_DEPTH  32  storage entries (>=2, any integer)
//   FWFT        0   0 = read-request mode (registered output); 1 = first-word-fall-through
//   AF_LEVEL    28  io_almost_full asserts when count >= AF_LEVEL (1..FIFO_DEPTH)
//   AE_LEVEL    4   io_almost_empty asserts when count <= AE_LEVEL (0..FIFO_DEPTH-1)
//   Derived: PTR_W = max(1,$clog2(FIFO_DEPTH)), CNT_W = $clog2(FIFO_DEPTH+1)
// PORTS
//   clock            in   1           single clock; all state on rising edge
//   reset            in   1           asynchronous, active-low reset
//   io_flush         in   1           synchronous clear of contents and flags
//   io_din           in   DATA_WIDTH  write data
//   io_din_v         in   1           write valid
//   io_din_r         out  1           write ready (= ~full)
//   io_dout          out  DATA_WIDTH  read data
//   io_dout_v        out  1           read data valid
//   io_dout_r        in   1           FWFT=0: read request; FWFT=1: consumer ready
//   io_count         out  CNT_W       entries held (0..FIFO_DEPTH), registered
//   io_almost_full   out  1           count >= AF_LEVEL
//   io_almost_empty  out  1           count <= AE_LEVEL
//   io_overflow      out  1           sticky: write attempted while full
// BEHAVIOUR
// - Reset (reset=0, async): pointers=0, count=0, io_dout=0, io_dout_v=0, io_overflow=0.
//   Hence io_din_r=1, io_almost_empty=1, io_almost_full=0. Memory contents are not reset.
// - full = (count==FIFO_DEPTH); empty = (count==0); both are decoded from the count register.
// - Push: io_din_v & ~full. Writes mem[wr_ptr]. wr_ptr wraps FIFO_DEPTH-1 -> 0.
// - Push when full: data is dropped, no state change except io_overflow<=1.
//   io_overflow holds until flush or reset.
// - Pop, FWFT=0: io_dout_r & ~empty. Next cycle io_dout=mem[rd_ptr] and io_dout_v=1.
//   io_dout_v is a one-cycle pulse per accepted pop (back-to-back pops keep it high).
//   io_dout holds its last value when no pop occurs. A request while empty is ignored.
// - Pop, FWFT=1: io_dout_v = ~empty; io_dout = empty ? 0 : mem[rd_ptr] (combinational from
//   registered state). Pop occurs on io_dout_v & io_dout_r.
// - rd_ptr wraps FIFO_DEPTH-1 -> 0 in both modes.
// - Latency from push at edge N: entry counted at N+1.
//   FWFT=1: io_dout_v can rise after N+1. FWFT=0: earliest pop request at N+1, data at N+2.
//   No write-to-read bypass when empty.
// - Simultaneous push and pop: both take effect and count is unchanged.
//   When full, the pop proceeds and the push is rejected (io_din_r=0 that cycle).
//   When empty, only the push proceeds.
// - io_count and the almost flags reflect the post-edge count.
//   Both almost flags may be high simultaneously.
// - io_flush=1 at an edge: pointers=0, count=0, io_overflow=0, io_dout_v=0.
//   io_dout is unchanged in FWFT=0. Flush overrides any same-cycle push/pop (both discarded).
// - Reset asserted mid-transfer: immediate clear per reset values.
//   The first push is accepted on the first edge after release.
// TESTING
// 1. Reset, FWFT=0, DEPTH=32: push 0x1..0x20 -> io_din_r=0 after 32nd, io_count=32,
//    io_almost_full=1 from count 28. A 33rd push -> io_overflow=1 and count stays 32.
// 2. FWFT=0, DEPTH=5 (non-pow2): 3 rounds of push 5 / pop 5 -> data returns in order,
//    one-cycle io_dout_v pulse per pop, pointers wrap correctly, count returns to 0.
// 3. FWFT=1: push 0xA5 at edge N -> io_dout_v=1, io_dout=0xA5 after N+1.
//    Hold io_dout_r=0 for 4 cycles -> stable. Then io_dout_r=1 -> io_dout_v=0, count=0.
// 4. Full FIFO, io_din_v=1 and io_dout_r=1 together -> only the pop occurs, count=DEPTH-1.
//    Next cycle both asserted again -> push and pop both occur, count stays DEPTH-1.
// 5. Count=10 with io_flush=1 plus a same-cycle push -> count=0, io_dout_v=0, io_overflow=0.
//    Subsequent pop requests are ignored until a new push.
// 6. Drop reset asynchronously mid-stream (count=7) -> outputs take reset values
//    without a clock edge. After release, push 0x3C / pop -> 0x3C is returned.

Source files
------------

// File: rtl/elastic_fifo.sv
// elastic_fifo: synchronous FIFO with arbitrary depth, selectable output mode
// (registered read-request or first-word-fall-through), occupancy count,
// almost-full/almost-empty flags, synchronous flush and a sticky overflow flag.
// Handshake: a write is accepted on an edge where io_din_v & io_din_r; a read
// is accepted on an edge where io_dout_r and the FIFO is not empty (in FWFT
// mode that is io_dout_v & io_dout_r). io_flush wins over both.
module elastic_fifo #(
    parameter int DATA_WIDTH = 32,
    parameter int FIFO_DEPTH = 32,
    parameter int FWFT       = 0,
    parameter int AF_LEVEL   = 28,
    parameter int AE_LEVEL   = 4,
    localparam int PTR_W     = (FIFO_DEPTH > 2) ? $clog2(FIFO_DEPTH) : 1,
    localparam int CNT_W     = $clog2(FIFO_DEPTH + 1)
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  io_flush,
    input  logic [DATA_WIDTH-1:0] io_din,
    input  logic                  io_din_v,
    output logic                  io_din_r,
    output logic [DATA_WIDTH-1:0] io_dout,
    output logic                  io_dout_v,
    input  logic                  io_dout_r,
    output logic [CNT_W-1:0]      io_count,
    output logic                  io_almost_full,
    output logic                  io_almost_empty,
    output logic                  io_overflow
);

    logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]      count_q, count_d;
    logic                  overflow_q, overflow_d;
    logic                  full, empty, push, pop;
    logic [DATA_WIDTH-1:0] rd_data;

    // Full/empty come straight from the count register, so they are glitch-free
    // and never depend on same-cycle inputs.
    assign full    = (count_q == CNT_W'(FIFO_DEPTH));
    assign empty   = (count_q == '0);
    assign push    = io_din_v & ~full & ~io_flush;
    assign pop     = io_dout_r & ~empty & ~io_flush;
    assign rd_data = mem_q[rd_ptr_q];

    assign io_din_r        = ~full;
    assign io_count        = count_q;
    assign io_almost_full  = (count_q >= CNT_W'(AF_LEVEL));
    assign io_almost_empty = (count_q <= CNT_W'(AE_LEVEL));
    assign io_overflow     = overflow_q;

    // Next-state for pointers, count and overflow; pointers wrap explicitly so
    // non-power-of-two depths work.
    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        overflow_d = overflow_q;
        if (io_flush) begin
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            count_d    = '0;
            overflow_d = 1'b0;
        end else begin
            if (push) begin
                wr_ptr_d = (wr_ptr_q == PTR_W'(FIFO_DEPTH - 1)) ? '0 : wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_d = (rd_ptr_q == PTR_W'(FIFO_DEPTH - 1)) ? '0 : rd_ptr_q + 1'b1;
            end
            if (push && !pop) begin
                count_d = count_q + 1'b1;
            end else if (pop && !push) begin
                count_d = count_q - 1'b1;
            end
            // A write attempt against a full FIFO is remembered until flush/reset,
            // even when a same-cycle pop frees a slot for the next cycle.
            if (io_din_v && full) begin
                overflow_d = 1'b1;
            end
        end
    end

    // Control state register with asynchronous active-low clear.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
        end
    end

    // Storage array; contents are deliberately not reset.
    always_ff @(posedge clock) begin
        if (push) begin
            mem_q[wr_ptr_q] <= io_din;
        end
    end

    generate
        if (FWFT == 0) begin : g_registered
            logic [DATA_WIDTH-1:0] dout_q, dout_d;
            logic                  dout_v_q, dout_v_d;

            // Read-request mode: capture the head on each accepted pop; data
            // holds otherwise and valid is a one-cycle pulse per pop.
            always_comb begin
                dout_d   = dout_q;
                dout_v_d = pop;
                if (pop) begin
                    dout_d = rd_data;
                end
            end

            // Output register with asynchronous active-low clear.
            always_ff @(posedge clock or negedge reset) begin
                if (!reset) begin
                    dout_q   <= '0;
                    dout_v_q <= 1'b0;
                end else begin
                    dout_q   <= dout_d;
                    dout_v_q <= dout_v_d;
                end
            end

            assign io_dout   = dout_q;
            assign io_dout_v = dout_v_q;
        end else begin : g_fwft
            // Head of the queue is presented directly; zero while empty.
            assign io_dout_v = ~empty;
            assign io_dout   = empty ? '0 : rd_data;
        end
    endgenerate

endmodule
